// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// over WIDTH cycles, followed by one sign-fix/select cycle. Supports a flush abort.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             is_div;
    logic             sel;
    logic             neg;

    logic             a_signed;
    logic             b_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             div_ovf;

    // Operand decode at accept: signedness, magnitudes and the two early-exit cases.
    always_comb begin
        a_signed = funct3[2] ? ~funct3[0] : (funct3[1] ^ funct3[0]);
        b_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
        sign_a   = a_signed & opA[WIDTH-1];
        sign_b   = b_signed & opB[WIDTH-1];
        mag_a    = sign_a ? -opA : opA;
        mag_b    = sign_b ? -opB : opB;
        div_zero = funct3[2] & (opB == '0);
        div_ovf  = funct3[2] & ~funct3[0]
                   & (opA == {1'b1, {(WIDTH-1){1'b0}}}) & (opB == '1);
    end

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply adds the multiplicand into the high half before shifting right; divide
    // shifts the remainder/quotient pair left and keeps the trial difference if it is non-negative.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_val;
    logic [WIDTH-1:0]   div_fix;
    logic [WIDTH-1:0]   fix_val;

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg ? -prod : prod;
        div_val  = sel ? acc_hi : acc_lo;
        div_fix  = neg ? -div_val : div_val;
        if (is_div)
            fix_val = div_fix;
        else if (sel)
            fix_val = prod_fix[2*WIDTH-1:WIDTH];
        else
            fix_val = prod_fix[WIDTH-1:0];
    end

    // Early paths preload the final quotient/remainder with neg cleared so FIX selects them unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            is_div <= 1'b0;
            sel    <= 1'b0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            is_div <= funct3[2];
                            sel    <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
                            count  <= '0;
                            busy   <= 1'b1;
                            if (div_zero) begin
                                opnd   <= mag_b;
                                acc_hi <= opA;
                                acc_lo <= '1;
                                neg    <= 1'b0;
                                state  <= FIX;
                            end else if (div_ovf) begin
                                opnd   <= mag_b;
                                acc_hi <= '0;
                                acc_lo <= opA;
                                neg    <= 1'b0;
                                state  <= FIX;
                            end else if (funct3[2]) begin
                                opnd   <= mag_b;
                                acc_hi <= '0;
                                acc_lo <= mag_a;
                                neg    <= funct3[1] ? sign_a : (sign_a ^ sign_b);
                                state  <= CALC;
                            end else begin
                                opnd   <= mag_a;
                                acc_hi <= '0;
                                acc_lo <= mag_b;
                                neg    <= sign_a ^ sign_b;
                                state  <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        if (is_div) begin
                            if (!diff[WIDTH]) begin
                                acc_hi <= diff[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_hi <= shifted[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        if (count == CW'(WIDTH - 1)) begin
                            count <= '0;
                            state <= FIX;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    FIX: begin
                        result <= fix_val;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected results go into a scoreboard queue at issue
// and are popped when done pulses; busy/done timing is checked every cycle.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         kill = 1'b0;
    logic [2:0]   funct3 = 3'b000;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    logic [W-1:0] sb[$];
    logic [W-1:0] last_result = '0;
    int           n_checks = 0;
    int           n_fail = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .opA    (opA),
        .opB    (opB),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Drives start for cycle 0 and records the expected result; returns in cycle 1.
    task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] exp);
        funct3 = op;
        opA    = a;
        opB    = b;
        start  = 1'b1;
        sb.push_back(exp);
        advance();
        start = 1'b0;
    endtask

    // Walks cycles 1..lat; optionally pulses a junk start in cycle poke_cyc. Returns in the done cycle.
    task automatic check_output(input string tag, input int lat, input int poke_cyc);
        logic [W-1:0] exp;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            if (cyc < lat) begin
                check_bit({tag, " busy"}, busy, 1'b1);
                check_bit({tag, " done early"}, done, 1'b0);
                check_val({tag, " result held"}, result, last_result);
                if (cyc == poke_cyc) begin
                    start  = 1'b1;
                    funct3 = 3'b101;
                    opA    = 32'h1234_5678;
                    opB    = 32'h0000_0003;
                end
                advance();
                start = 1'b0;
            end else begin
                check_bit({tag, " done"}, done, 1'b1);
                check_bit({tag, " busy at done"}, busy, 1'b0);
                n_checks++;
                assert (sb.size() > 0) else begin
                    n_fail++;
                    $error("[TB] FAIL %s scoreboard: observed empty expected entry", tag);
                end
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    check_val({tag, " result"}, result, exp);
                    last_result = exp;
                end
            end
        end
    endtask

    initial begin
        #1;
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset done", done, 1'b0);
        check_val("reset result", result, '0);
        repeat (2) advance();
        rst_n = 1'b1;
        advance();

        apply_stimulus(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        check_output("MUL 7*-3 poked", W + 2, 5);

        apply_stimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        check_output("MULH", W + 2, 0);
        apply_stimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        check_output("MULHU", W + 2, 0);
        apply_stimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_output("MULHSU", W + 2, 0);

        apply_stimulus(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        check_output("DIV -7/2", W + 2, 0);
        apply_stimulus(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        check_output("REM -7/2", W + 2, 0);
        apply_stimulus(3'b101, 32'd100, 32'd7, 32'd14);
        check_output("DIVU 100/7", W + 2, 0);
        apply_stimulus(3'b111, 32'd100, 32'd7, 32'd2);
        check_output("REMU 100/7", W + 2, 0);

        // Abort a DIV in cycle 10; the scoreboard entry is withdrawn since no done may follow.
        apply_stimulus(3'b100, 32'd1000, 32'd3, 32'd333);
        sb.delete(sb.size() - 1);
        for (int cyc = 1; cyc < 10; cyc++) begin
            check_bit("kill pre busy", busy, 1'b1);
            advance();
        end
        kill = 1'b1;
        check_bit("kill cycle busy", busy, 1'b1);
        advance();
        kill = 1'b0;
        check_bit("kill busy drop", busy, 1'b0);
        for (int cyc = 0; cyc < W + 8; cyc++) begin
            check_bit("kill no done", done, 1'b0);
            check_val("kill result held", result, last_result);
            advance();
        end

        apply_stimulus(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
        check_output("DIVU 5/0", 2, 0);
        apply_stimulus(3'b110, 32'd5, 32'd0, 32'd5);
        check_output("REM 5/0", 2, 0);
        apply_stimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        check_output("DIV ovf", 2, 0);
        apply_stimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        check_output("REM ovf", 2, 0);

        apply_stimulus(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        check_output("MUL again", W + 2, 0);
        advance();

        // Async reset mid-CALC must clear outputs without waiting for a clock edge.
        apply_stimulus(3'b000, 32'd9, 32'd9, 32'd81);
        sb.delete(sb.size() - 1);
        for (int cyc = 1; cyc < 10; cyc++) advance();
        check_bit("pre-reset busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("async reset busy", busy, 1'b0);
        check_bit("async reset done", done, 1'b0);
        check_val("async reset result", result, '0);
        last_result = '0;
        advance();
        rst_n = 1'b1;
        advance();
        check_bit("post-reset busy", busy, 1'b0);

        apply_stimulus(3'b011, 32'd3, 32'd5, 32'd0);
        check_output("MULHU 3*5", W + 2, 0);
        advance();
        check_bit("idle after done", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
